shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Controller plus 5-bit register datapath that sequences the team's shift-register family: parallel load, right shift, left shift, ring, and twisted-ring (Johnson). A requester issues one command: a mode and a shift count under a start/busy/done handshake. The block then performs exactly that many shifts and signals completion. It replaces the free-running shift chains with one command-driven unit that upstream control logic can schedule.

## Interface
- WIDTH, 5: register width; q[WIDTH-1] is stage "a" (leftmost), q[0] is stage "e".
- CNT_W, 4: width of the shift-count field; maximum count 2**CNT_W-1.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  command request; sampled only in IDLE.
- mode  in  3  command: 000 hold, 001 shift right, 010 shift left, 011 ring right, 100 twisted right, 101 parallel load, 110/111 reserved (treated as hold).
- count  in  CNT_W  number of shifts; ignored for parallel load.
- ser_in  in  1  serial input bit.
- par_in  in  WIDTH  parallel load value.
- q  out  WIDTH  register contents.
- ser_out  out  1  bit shifted out by the most recent shift (registered).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE. Encoding lives in the package.
- IDLE:
  - start=1 latches mode and count into internal registers and sets rem=count.
  - Parallel load or count=0 goes directly to DONE; otherwise the block goes to RUN.
  - q is unchanged on this edge.
- Parallel load (101): q<=par_in on the start edge. DONE follows, with no RUN cycles.
- RUN: one shift per edge.
  - rem decrements on each shift.
  - When rem==1 the block shifts, then enters DONE.
- Shift rules per edge:
  - right: q<={ser_in, q[W-1:1]}, ser_out<=q[0].
  - left: q<={q[W-2:0], ser_in}, ser_out<=q[W-1].
  - ring: q<={q[0]|ser_in, q[W-1:1]}, ser_out<=q[0].
  - twisted: q<={~q[0]|ser_in, q[W-1:1]}, ser_out<=q[0].
  - hold/reserved: q and ser_out unchanged, but count is still consumed.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start while busy is ignored, not queued. mode, count, ser_in and par_in changes during RUN do not affect the latched command. ser_in is sampled live on each shift edge.

## Timing
- Reset values: q=0, ser_out=0, busy=0, done=0, state=IDLE, rem=0.
- Start sampled at edge E0.
  - Shifts occur at edges E1..EN.
  - done is high in the cycle after EN and is deasserted at EN+1.
  - busy is high from after E0 until EN+1.
- count=0 or parallel load: done is high in the cycle after E0, and busy is high for one cycle.
- Back-to-back commands: the earliest new start is accepted at the edge where done falls (state IDLE during that cycle). Throughput is N+2 cycles per command.
- Reset mid-RUN aborts immediately: all outputs go to reset values and no done pulse is issued.

## Configuration
- SHSEQ_PRESET_EN defined:
  - Adds input port preset (1 bit). preset=1 in IDLE synchronously sets q to all ones and ser_out to 0, which is the serial-to-parallel marker preset.
  - Priority: reset > preset > start. When preset and start are high together, preset wins and start is dropped.
  - preset is ignored while busy.
- Undefined: no preset port, no preset logic. All other behaviour is identical.

## Structure
- Package shseq_pkg holds:
  - mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_RING, MODE_TWIST, MODE_LOAD.
  - state encoding ST_IDLE, ST_RUN, ST_DONE.
  - default WIDTH/CNT_W constants.
- Sub-module shseq_datapath: the WIDTH-bit register, next-value mux and ser_out flop. It is driven by a shift-enable, a latched mode and a load-enable from the FSM.
- Top: FSM, rem counter, command latch, handshake outputs.

## Test plan
- Load then shift right: start mode=101 par_in=10110 gives q=10110 and a done pulse. Then mode=001 count=2 ser_in=0 gives q=00101 and ser_out=1. done is high 3 cycles after the start edge.
- Ring right: q=00001, mode=011, count=5, ser_in=0 gives q=10000 after the 1st shift and q=00001 at done.
- Twisted right: q=00000, mode=100, ser_in=0, count=5 gives q=11111. A second command with count=5 returns q=00000. count=10 from 00000 also gives 00000.
- Shift left with ser_in=1: q=00001, mode=010, count=3 gives q=01111. A start pulsed mid-run is ignored: exactly one done pulse, and busy stays high for 4 cycles.
- count=0 with mode=001: q unchanged, done in the cycle after the start edge, busy for 1 cycle.
- Reset asserted asynchronously at shift 2 of a count=4 command: q=00000, busy=0, done=0 immediately and no later done pulse. With SHSEQ_PRESET_EN, preset in IDLE gives q=11111.

Source files
------------

// File: rtl/shseq_pkg.sv
`default_nettype none
// ============================================================================
// Package   : shseq_pkg
// Purpose   : Shared constants for the shift_sequencer slice: default
//             geometry, command mode encodings and FSM state encoding.
// Revision  : 1.0 - initial release
// ============================================================================
package shseq_pkg;

    // Default geometry of the sequenced register
    localparam int DEF_WIDTH = 5;
    localparam int DEF_CNT_W = 4;
    localparam int MODE_W    = 3;

    // Command mode encodings; 3'b110 and 3'b111 are reserved and act as hold
    localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR   = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL   = 3'b010;
    localparam logic [MODE_W-1:0] MODE_RING  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_TWIST = 3'b100;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b101;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : shseq_pkg
`default_nettype wire

// File: rtl/shseq_datapath.sv
`default_nettype none
// ============================================================================
// Module    : shseq_datapath
// Purpose   : WIDTH-bit shift register with its next-value mux and the
//             registered serial-out flop. Stage "a" is q_o[WIDTH-1], stage
//             "e" is q_o[0].
// Ports     : clk, reset      - clock, asynchronous active-high reset
//             shift_en_i      - perform one shift of the latched mode
//             load_en_i       - parallel load par_in_i (takes priority over shift)
//             preset_en_i     - force all ones / ser_out 0 (SHSEQ_PRESET_EN only)
//             mode_i          - latched command mode
//             ser_in_i        - serial input bit, sampled live
//             par_in_i        - parallel load value
//             q_o, ser_out_o  - register contents, last shifted-out bit
// Config    : SHSEQ_PRESET_EN adds preset_en_i
// Revision  : 1.0 - initial release
// ============================================================================
module shseq_datapath
    import shseq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en_i,
    input  logic              load_en_i,
`ifdef SHSEQ_PRESET_EN
    input  logic              preset_en_i,
`endif
    input  logic [MODE_W-1:0] mode_i,
    input  logic              ser_in_i,
    input  logic [WIDTH-1:0]  par_in_i,
    output logic [WIDTH-1:0]  q_o,
    output logic              ser_out_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ser_out_q;
    logic             ser_out_d;
    logic             w_preset;

`ifdef SHSEQ_PRESET_EN
    assign w_preset = preset_en_i;
`else
    assign w_preset = 1'b0;
`endif

    always_comb begin
        q_d       = q_q;
        ser_out_d = ser_out_q;
        if (w_preset) begin
            // Serial-to-parallel marker: all ones, no bit shifted out yet
            q_d       = '1;
            ser_out_d = 1'b0;
        end else if (load_en_i) begin
            q_d = par_in_i;
        end else if (shift_en_i) begin
            case (mode_i)
                MODE_SHR: begin
                    q_d       = {ser_in_i, q_q[WIDTH-1:1]};
                    ser_out_d = q_q[0];
                end
                MODE_SHL: begin
                    q_d       = {q_q[WIDTH-2:0], ser_in_i};
                    ser_out_d = q_q[WIDTH-1];
                end
                MODE_RING: begin
                    q_d       = {q_q[0] | ser_in_i, q_q[WIDTH-1:1]};
                    ser_out_d = q_q[0];
                end
                MODE_TWIST: begin
                    q_d       = {~q_q[0] | ser_in_i, q_q[WIDTH-1:1]};
                    ser_out_d = q_q[0];
                end
                // Hold and reserved codes leave the register untouched
                default: begin
                    q_d       = q_q;
                    ser_out_d = ser_out_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q       <= '0;
            ser_out_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            ser_out_q <= ser_out_d;
        end
    end

    assign q_o       = q_q;
    assign ser_out_o = ser_out_q;

endmodule : shseq_datapath
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module    : shift_sequencer
// Purpose   : Command-driven shift-register sequencer. One start request
//             latches a mode and a shift count; the block then performs
//             exactly that many shifts and pulses done for one cycle.
// Ports     : clk, reset  - clock, asynchronous active-high reset
//             start       - command request (sampled only in IDLE)
//             mode, count - command mode and number of shifts
//             ser_in      - serial input bit (sampled live on each shift)
//             par_in      - parallel load value
//             preset      - all-ones preset in IDLE (SHSEQ_PRESET_EN only)
//             q, ser_out  - register contents, last shifted-out bit
//             busy, done  - handshake: busy while not IDLE, done pulse
// Config    : SHSEQ_PRESET_EN adds the preset input and its logic
// Revision  : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shseq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef SHSEQ_PRESET_EN
    input  logic              preset,
`endif
    input  logic [MODE_W-1:0] mode,
    input  logic [CNT_W-1:0]  count,
    input  logic              ser_in,
    input  logic [WIDTH-1:0]  par_in,
    output logic [WIDTH-1:0]  q,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    state_t              state_q;
    logic [CNT_W-1:0]    rem_q;
    logic [MODE_W-1:0]   mode_q;
    logic                busy_q;
    logic                done_q;

    logic                w_idle;
    logic                w_preset;
    logic                w_accept;
    logic                w_load_en;
    logic                w_shift_en;
    logic                w_immediate;

`ifdef SHSEQ_PRESET_EN
    // Preset is only honoured in IDLE and outranks a simultaneous start
    assign w_preset = preset & w_idle;
`else
    assign w_preset = 1'b0;
`endif

    assign w_idle      = (state_q == ST_IDLE);
    assign w_accept    = w_idle & start & ~w_preset;
    assign w_load_en   = w_accept & (mode == MODE_LOAD);
    assign w_shift_en  = (state_q == ST_RUN);
    // Loads and zero-count commands skip RUN entirely
    assign w_immediate = (mode == MODE_LOAD) || (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= MODE_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (w_accept) begin
                        mode_q <= mode;
                        rem_q  <= count;
                        busy_q <= 1'b1;
                        if (w_immediate) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_q - CNT_W'(1);
                    // The shift on this edge is the last one; rem of zero
                    // cannot occur here but is treated as last to stay safe
                    if (rem_q <= CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    shseq_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .shift_en_i  (w_shift_en),
        .load_en_i   (w_load_en),
`ifdef SHSEQ_PRESET_EN
        .preset_en_i (w_preset),
`endif
        .mode_i      (mode_q),
        .ser_in_i    (ser_in),
        .par_in_i    (par_in),
        .q_o         (q),
        .ser_out_o   (ser_out)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module    : tb_shift_sequencer
// Purpose   : Self-checking bench for shift_sequencer. A behavioural model
//             tracks the register as an integer value and applies each
//             mode's rule arithmetically; every command is checked cycle by
//             cycle for q, ser_out, busy and done.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] mode;
    logic [3:0] count;
    logic       ser_in;
    logic [4:0] par_in;
    logic [4:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;
`ifdef SHSEQ_PRESET_EN
    logic       preset;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: register value (stage a = weight 16) and last bit out
    int mq  = 0;
    int mso = 0;

    shift_sequencer #(
        .WIDTH (5),
        .CNT_W (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
`ifdef SHSEQ_PRESET_EN
        .preset  (preset),
`endif
        .mode    (mode),
        .count   (count),
        .ser_in  (ser_in),
        .par_in  (par_in),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // One shift of the model, expressed as arithmetic on the register value
    function automatic void model_shift(input int m, input int s);
        int lsb;
        int msb;
        lsb = mq % 2;
        msb = mq / 16;
        case (m)
            1: begin mso = lsb; mq = mq / 2 + s * 16; end
            2: begin mso = msb; mq = (mq * 2) % 32 + s; end
            3: begin mso = lsb; mq = mq / 2 + (lsb | s) * 16; end
            4: begin mso = lsb; mq = mq / 2 + ((1 - lsb) | s) * 16; end
            default: ;
        endcase
    endfunction

    // Issue one command starting at a negedge; returns at the negedge after
    // the edge where done falls, so a following call is back-to-back.
    // ser_sel: 0 = ser_in low, 1 = ser_in high, 2 = random.
    task automatic run_cmd(input int m, input int n, input int p, input int ser_sel,
                           input int midstart_at, input bit scramble, input string tag);
        bit immediate;
        int s;
        immediate = (m == 5) || (n == 0);
        mode   = 3'(m);
        count  = 4'(n);
        par_in = 5'(p);
        ser_in = 1'($urandom_range(1, 0));
        start  = 1'b1;
        @(posedge clk);
        if (m == 5) mq = p;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== immediate || q !== 5'(mq) || ser_out !== 1'(mso)) begin
            failures++;
            $display("FAIL %s start: busy=%b done=%b q=%b so=%b expected busy=1 done=%b q=%b so=%b",
                     tag, busy, done, q, ser_out, immediate, 5'(mq), 1'(mso));
        end
        if (!immediate) begin
            for (int k = 1; k <= n; k++) begin
                if (ser_sel == 2) s = int'($urandom_range(1, 0));
                else              s = ser_sel;
                ser_in = 1'(s);
                start  = (k == midstart_at);
                if (scramble) begin
                    mode   = 3'($urandom_range(7, 0));
                    count  = 4'($urandom_range(15, 0));
                    par_in = 5'($urandom_range(31, 0));
                end
                @(posedge clk);
                model_shift(m, s);
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (busy !== 1'b1 || done !== (k == n) || q !== 5'(mq) || ser_out !== 1'(mso)) begin
                    failures++;
                    $display("FAIL %s shift %0d: busy=%b done=%b q=%b so=%b expected busy=1 done=%b q=%b so=%b",
                             tag, k, busy, done, q, ser_out, (k == n), 5'(mq), 1'(mso));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 5'(mq) || ser_out !== 1'(mso)) begin
            failures++;
            $display("FAIL %s end: busy=%b done=%b q=%b so=%b expected busy=0 done=0 q=%b so=%b",
                     tag, busy, done, q, ser_out, 5'(mq), 1'(mso));
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        mode   = 3'd0;
        count  = 4'd0;
        ser_in = 1'b0;
        par_in = 5'd0;
`ifdef SHSEQ_PRESET_EN
        preset = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq  = 0;
        mso = 0;
        @(negedge clk);
        checks++;
        if (q !== 5'b00000 || ser_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: q=%b so=%b busy=%b done=%b expected all zero",
                     q, ser_out, busy, done);
        end
    endtask

    task automatic test_load_shift_right();
        run_cmd(5, 7, 5'b10110, 0, -1, 1'b0, "load10110");
        checks++;
        if (q !== 5'b10110) begin
            failures++;
            $display("FAIL load_value: q=%b expected 10110", q);
        end
        run_cmd(1, 2, 0, 0, -1, 1'b0, "shr2");
        checks++;
        if (q !== 5'b00101 || ser_out !== 1'b1) begin
            failures++;
            $display("FAIL shr2_value: q=%b so=%b expected q=00101 so=1", q, ser_out);
        end
    endtask

    task automatic test_ring();
        run_cmd(5, 0, 5'b00001, 0, -1, 1'b0, "load00001");
        run_cmd(3, 5, 0, 0, -1, 1'b0, "ring5");
        checks++;
        if (q !== 5'b00001) begin
            failures++;
            $display("FAIL ring5_value: q=%b expected 00001", q);
        end
    endtask

    task automatic test_twist();
        run_cmd(5, 0, 0, 0, -1, 1'b0, "load00000");
        run_cmd(4, 5, 0, 0, -1, 1'b0, "twist5a");
        checks++;
        if (q !== 5'b11111) begin
            failures++;
            $display("FAIL twist5a_value: q=%b expected 11111", q);
        end
        run_cmd(4, 5, 0, 0, -1, 1'b0, "twist5b");
        checks++;
        if (q !== 5'b00000) begin
            failures++;
            $display("FAIL twist5b_value: q=%b expected 00000", q);
        end
        run_cmd(4, 10, 0, 0, -1, 1'b0, "twist10");
        checks++;
        if (q !== 5'b00000) begin
            failures++;
            $display("FAIL twist10_value: q=%b expected 00000", q);
        end
    endtask

    task automatic test_shift_left_midstart();
        run_cmd(5, 0, 5'b00001, 0, -1, 1'b0, "load00001b");
        run_cmd(2, 3, 0, 1, 2, 1'b0, "shl3_midstart");
        checks++;
        if (q !== 5'b01111) begin
            failures++;
            $display("FAIL shl3_value: q=%b expected 01111", q);
        end
    endtask

    task automatic test_count_zero();
        run_cmd(5, 0, 5'b11010, 0, -1, 1'b0, "load11010");
        run_cmd(1, 0, 0, 1, -1, 1'b0, "shr0");
        checks++;
        if (q !== 5'b11010) begin
            failures++;
            $display("FAIL count0_value: q=%b expected 11010", q);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_cmd(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)),
                    int'($urandom_range(31, 0)), 2, int'($urandom_range(6, 0)), 1'b1, "random");
        end
    endtask

    task automatic test_back_to_back();
        // Each call starts at the first accepting edge after the previous done
        run_cmd(5, 3, 5'b10011, 2, -1, 1'b0, "b2b_load");
        run_cmd(1, 1, 0, 2, -1, 1'b0, "b2b_shr");
        run_cmd(3, 2, 0, 2, -1, 1'b0, "b2b_ring");
        run_cmd(2, 0, 0, 2, -1, 1'b0, "b2b_zero");
        run_cmd(4, 4, 0, 2, -1, 1'b0, "b2b_twist");
    endtask

    task automatic test_reset_midrun();
        bit saw_done;
        run_cmd(5, 0, 5'b10101, 0, -1, 1'b0, "load10101");
        mode   = 3'd1;
        count  = 4'd4;
        ser_in = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (q !== 5'b00000 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_midrun: q=%b busy=%b done=%b so=%b expected all zero",
                     q, busy, done, ser_out);
        end
        @(negedge clk);
        reset = 1'b0;
        mq  = 0;
        mso = 0;
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || q !== 5'b00000) begin
            failures++;
            $display("FAIL reset_no_done: late done/busy=%b q=%b expected 0 and 00000", saw_done, q);
        end
    endtask

`ifdef SHSEQ_PRESET_EN
    task automatic test_preset();
        preset = 1'b1;
        start  = 1'b1;
        mode   = 3'd1;
        count  = 4'd3;
        @(posedge clk);
        @(negedge clk);
        preset = 1'b0;
        start  = 1'b0;
        mq  = 31;
        mso = 0;
        checks++;
        if (q !== 5'b11111 || ser_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL preset: q=%b so=%b busy=%b done=%b expected 11111 0 0 0",
                     q, ser_out, busy, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_shift_right();
        test_ring();
        test_twist();
        test_shift_left_midstart();
        test_count_zero();
        test_back_to_back();
        test_random();
        test_reset_midrun();
`ifdef SHSEQ_PRESET_EN
        test_preset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_sequencer
`default_nettype wire
